// File: rtl/ball_sprite_engine.sv
// Square-ball sprite generator: registered RGB565 pixel output plus a once-per-frame
// position update FSM. Optional bounce counter enabled with BALL_BOUNCE_COUNT_EN.
module ball_sprite_engine #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned SIZE       = 4,
  parameter int unsigned H_INIT     = 128,
  parameter int unsigned V_INIT     = 128,
  parameter int unsigned SPEED_W    = 4,
  parameter logic [15:0] BALL_COLOR = 16'hFFFF,
  parameter logic [15:0] BG_COLOR   = 16'h0000
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [15:0]        row_i,
  input  logic [15:0]        column_i,
  input  logic [SPEED_W-1:0] speed_h_i,
  input  logic [SPEED_W-1:0] speed_v_i,
  input  logic               pause_i,
  output logic [15:0]        rgb_o,
  output logic [15:0]        ball_h_o,
  output logic [15:0]        ball_v_o,
  output logic               bounce_h_o,
  output logic               bounce_v_o,
  output logic               frame_tick_o
`ifdef BALL_BOUNCE_COUNT_EN
  ,
  output logic [15:0]        bounce_cnt_o
`endif
);

  localparam logic [16:0] MaxH    = 17'(H_ACTIVE - SIZE);
  localparam logic [16:0] MaxV    = 17'(V_ACTIVE - SIZE);
  localparam logic [16:0] Size17  = 17'(SIZE);
  localparam logic [15:0] HActive = 16'(H_ACTIVE);
  localparam logic [15:0] VActive = 16'(V_ACTIVE);

  typedef enum logic [1:0] {StWait, StUpdH, StUpdV} state_e;

  typedef struct packed {
    logic [15:0] pos;
    logic        dir;
    logic        bounce;
  } step_t;

  // dir = 1 means moving towards larger coordinates; walls clamp exactly.
  function automatic step_t axis_step(input logic [15:0] pos, input logic dir,
                                      input logic [SPEED_W-1:0] speed,
                                      input logic [16:0] max_pos);
    step_t       res;
    logic [16:0] p17;
    logic [16:0] s17;
    logic [16:0] sum;
    logic [16:0] diff;
    p17  = {1'b0, pos};
    s17  = 17'(speed);
    sum  = p17 + s17;
    diff = p17 - s17;
    res  = '{pos: pos, dir: dir, bounce: 1'b0};
    if (dir) begin
      if (sum >= max_pos) res = '{pos: max_pos[15:0], dir: 1'b0, bounce: 1'b1};
      else                res.pos = sum[15:0];
    end else begin
      if (p17 <= s17) res = '{pos: 16'd0, dir: 1'b1, bounce: 1'b1};
      else            res.pos = diff[15:0];
    end
    return res;
  endfunction

  state_e      state_q, state_d;
  logic [15:0] ball_h_q, ball_h_d, ball_v_q, ball_v_d;
  logic        dir_h_q, dir_h_d, dir_v_q, dir_v_d;
  logic        bounce_h_q, bounce_h_d, bounce_v_q, bounce_v_d;
  logic        match_q, tick_q, tick_d;
  logic [15:0] rgb_q, rgb_d;
  logic        match, hit, visible;
  step_t       step_res;

  // Edge-detect the match so a scan parked on the trigger pixel fires only once.
  assign match  = (row_i == VActive) && (column_i == 16'd0);
  assign tick_d = match && !match_q;

  always_comb begin
    state_d    = state_q;
    ball_h_d   = ball_h_q;
    ball_v_d   = ball_v_q;
    dir_h_d    = dir_h_q;
    dir_v_d    = dir_v_q;
    bounce_h_d = 1'b0;
    bounce_v_d = 1'b0;
    step_res   = '0;
    unique case (state_q)
      StWait: if (tick_q && !pause_i) state_d = StUpdH;
      StUpdH: begin
        step_res   = axis_step(ball_h_q, dir_h_q, speed_h_i, MaxH);
        ball_h_d   = step_res.pos;
        dir_h_d    = step_res.dir;
        bounce_h_d = step_res.bounce;
        state_d    = StUpdV;
      end
      StUpdV: begin
        step_res   = axis_step(ball_v_q, dir_v_q, speed_v_i, MaxV);
        ball_v_d   = step_res.pos;
        dir_v_d    = step_res.dir;
        bounce_v_d = step_res.bounce;
        state_d    = StWait;
      end
      default: state_d = StWait;
    endcase
  end

  always_comb begin
    visible = (row_i < VActive) && (column_i < HActive);
    hit     = ({1'b0, column_i} >= {1'b0, ball_h_q}) &&
              ({1'b0, column_i} <  ({1'b0, ball_h_q} + Size17)) &&
              ({1'b0, row_i}    >= {1'b0, ball_v_q}) &&
              ({1'b0, row_i}    <  ({1'b0, ball_v_q} + Size17));
    rgb_d   = (visible && hit) ? BALL_COLOR : BG_COLOR;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StWait;
      ball_h_q   <= 16'(H_INIT);
      ball_v_q   <= 16'(V_INIT);
      dir_h_q    <= 1'b0;
      dir_v_q    <= 1'b1;
      bounce_h_q <= 1'b0;
      bounce_v_q <= 1'b0;
      match_q    <= 1'b0;
      tick_q     <= 1'b0;
      rgb_q      <= BG_COLOR;
    end else begin
      state_q    <= state_d;
      ball_h_q   <= ball_h_d;
      ball_v_q   <= ball_v_d;
      dir_h_q    <= dir_h_d;
      dir_v_q    <= dir_v_d;
      bounce_h_q <= bounce_h_d;
      bounce_v_q <= bounce_v_d;
      match_q    <= match;
      tick_q     <= tick_d;
      rgb_q      <= rgb_d;
    end
  end

  assign rgb_o        = rgb_q;
  assign ball_h_o     = ball_h_q;
  assign ball_v_o     = ball_v_q;
  assign bounce_h_o   = bounce_h_q;
  assign bounce_v_o   = bounce_v_q;
  assign frame_tick_o = tick_q;

`ifdef BALL_BOUNCE_COUNT_EN
  logic [15:0] bounce_cnt_q, bounce_cnt_d;

  // Pulses never coincide, so a corner adds one on each of two cycles.
  assign bounce_cnt_d = bounce_cnt_q + {15'd0, bounce_h_q} + {15'd0, bounce_v_q};

  always_ff @(posedge clk_i) begin
    if (reset_i) bounce_cnt_q <= 16'd0;
    else         bounce_cnt_q <= bounce_cnt_d;
  end

  assign bounce_cnt_o = bounce_cnt_q;
`endif

endmodule

// File: tb/tb_ball_sprite_engine.sv
// Bench for ball_sprite_engine: directed steps followed by randomized frames, checked
// against a simple position/direction model of the bouncing ball.
module tb_ball_sprite_engine;
  localparam int HA = 640;
  localparam int VA = 480;
  localparam int SZ = 4;
  localparam int MAXH = HA - SZ;
  localparam int MAXV = VA - SZ;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] row, col;
  logic [3:0]  speed_h, speed_v;
  logic        pause;
  logic [15:0] rgb, ball_h, ball_v;
  logic        bounce_h, bounce_v, tick;
`ifdef BALL_BOUNCE_COUNT_EN
  logic [15:0] bounce_cnt;
`endif

  always #5 clk = ~clk;

  ball_sprite_engine dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .row_i       (row),
    .column_i    (col),
    .speed_h_i   (speed_h),
    .speed_v_i   (speed_v),
    .pause_i     (pause),
    .rgb_o       (rgb),
    .ball_h_o    (ball_h),
    .ball_v_o    (ball_v),
    .bounce_h_o  (bounce_h),
    .bounce_v_o  (bounce_v),
    .frame_tick_o(tick)
`ifdef BALL_BOUNCE_COUNT_EN
    ,
    .bounce_cnt_o(bounce_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;
  int mh, mv, mcnt;
  bit mdh, mdv;  // 1 = moving towards larger coordinate

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    mh = 128; mv = 128; mdh = 0; mdv = 1; mcnt = 0;
  endtask

  task automatic axis(inout int pos, inout bit dir, input int spd, input int maxp,
                      output bit b);
    b = 0;
    if (dir) begin
      if (pos + spd >= maxp) begin pos = maxp; dir = 0; b = 1; end
      else pos = pos + spd;
    end else begin
      if (pos <= spd) begin pos = 0; dir = 1; b = 1; end
      else pos = pos - spd;
    end
    if (b) mcnt++;
  endtask

  function automatic logic [15:0] model_rgb(input int r, input int c);
    if (r < VA && c < HA && c >= mh && c < mh + SZ && r >= mv && r < mv + SZ) return 16'hFFFF;
    return 16'h0000;
  endfunction

  task automatic pix(input int r, input int c);
    row = 16'(r); col = 16'(c);
    step();
    check("rgb", rgb, model_rgb(r, c));
  endtask

  // One vblank trigger and the full update sequence; speeds are only valid in their UPD cycle.
  task automatic do_frame(input bit pz, input int sh, input int sv);
    bit b;
    row = 16'(VA); col = 0; pause = pz; speed_h = 4'(sh); speed_v = 4'($urandom_range(0, 15));
    step();
    check("tick_hi", tick, 1);
    row = 16'(VA + 1);
    step();
    check("tick_lo", tick, 0);
    check("h_hold", ball_h, mh);
    pause = 1'($urandom_range(0, 1));
    step();
    b = 0;
    if (!pz) axis(mh, mdh, sh, MAXH, b);
    check("ball_h", ball_h, mh);
    check("bounce_h", bounce_h, b);
    speed_h = 4'($urandom_range(0, 15));
    speed_v = 4'(sv);
    step();
    b = 0;
    if (!pz) axis(mv, mdv, sv, MAXV, b);
    check("ball_v", ball_v, mv);
    check("bounce_v", bounce_v, b);
    check("bounce_h_end", bounce_h, 0);
    speed_v = 4'($urandom_range(0, 15));
    step();
    check("bounce_v_end", bounce_v, 0);
    check("h_stable", ball_h, mh);
    check("v_stable", ball_v, mv);
`ifdef BALL_BOUNCE_COUNT_EN
    check("bounce_cnt", bounce_cnt, 16'(mcnt));
`endif
  endtask

  initial begin
    int r, c;
    reset = 1; row = 0; col = 0; speed_h = 0; speed_v = 0; pause = 0;
    model_reset();
    step();
    step();
    reset = 0;
    step();
    check("rst_h", ball_h, 128);
    check("rst_v", ball_v, 128);
    check("rst_rgb", rgb, 16'h0000);
    check("rst_bh", bounce_h, 0);
    check("rst_bv", bounce_v, 0);
    check("rst_tick", tick, 0);

    for (int i = 127; i <= 132; i++) pix(128, i);
    pix(132, 128);
    pix(131, 131);

    // Parked scan on the trigger pixel must tick once only.
    pause = 1; row = 16'(VA); col = 0;
    step();
    check("stall_tick0", tick, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_tick", tick, 0);
    end
    row = 0;
    step();
    check("stall_pos", ball_h, 128);

    do_frame(0, 2, 2);
    check("dir_h126", ball_h, 126);
    check("dir_v130", ball_v, 130);
    do_frame(1, 2, 2);
    check("pause_h", ball_h, 126);

    // Reset landing on the UPD_H cycle.
    row = 16'(VA); col = 0; pause = 0; speed_h = 4'd5; speed_v = 4'd5;
    step();
    row = 16'(VA + 1);
    step();
    reset = 1;
    step();
    reset = 0;
    model_reset();
    check("midrst_h", ball_h, 128);
    check("midrst_v", ball_v, 128);
    check("midrst_bh", bounce_h, 0);
    step();
    check("midrst_v2", ball_v, 128);
    check("midrst_bh2", bounce_h, 0);
    step();
    check("midrst_bv", bounce_v, 0);

    for (int f = 0; f < 250; f++) begin
      do_frame($urandom_range(0, 7) == 0, $urandom_range(0, 15), $urandom_range(0, 15));
      for (int k = 0; k < 3; k++) begin
        r = (mv + $urandom_range(0, SZ + 3) - 2) & 16'hFFFF;
        c = (mh + $urandom_range(0, SZ + 3) - 2) & 16'hFFFF;
        pix(r, c);
      end
      r = $urandom_range(0, 1023);
      c = $urandom_range(0, 1023);
      if (r == VA && c == 0) c = 1;
      pix(r, c);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ball_sprite_engine.md
Name: ball_sprite_engine

Overview:
Parametrised square-ball sprite generator for the vgaDriver pixel pipeline. Takes the driver's row/column scan position and produces the 16-bit RGB565 pixel word for the driver's rgb_i. Ball position updates once per frame, during vertical blank, through a small update FSM. Size, speed, bounds, colours and start point are configurable. Bounces are clamped exactly at the edges, with no overshoot.

Parameters:
H_ACTIVE, 640, visible columns
V_ACTIVE, 480, visible rows
SIZE, 4, ball edge length in pixels (1..64)
H_INIT, 128, reset column of ball top-left
V_INIT, 128, reset row of ball top-left
SPEED_W, 4, width of speed inputs
BALL_COLOR, 16'hFFFF, RGB565 ball colour
BG_COLOR, 16'h0000, RGB565 background colour

Ports:
clk_i  in  1  system clock, same clock as vgaDriver
reset_i  in  1  synchronous active-high reset
row_i  in  16  current scan row from vgaDriver row_o
column_i  in  16  current scan column from vgaDriver column_o
speed_h_i  in  SPEED_W  horizontal step magnitude per frame
speed_v_i  in  SPEED_W  vertical step magnitude per frame
pause_i  in  1  freeze motion while high
rgb_o  out  16  pixel word to vgaDriver rgb_i
ball_h_o  out  16  current ball column (top-left)
ball_v_o  out  16  current ball row (top-left)
bounce_h_o  out  1  one-cycle pulse on horizontal wall bounce
bounce_v_o  out  1  one-cycle pulse on vertical wall bounce
frame_tick_o  out  1  one-cycle pulse at start of vblank

Behaviour:
- Reset (reset_i sampled high on a clk_i edge): ball_h=H_INIT, ball_v=V_INIT, dir_h=negative, dir_v=positive, FSM=WAIT, rgb_o=BG_COLOR, all pulses 0. Reset mid-FSM aborts the update and restores the init values.
- Frame tick: frame_tick_o is a registered pulse, high for exactly one cycle after the cycle where row_i==V_ACTIVE && column_i==0. The input compare fires once per frame: it is qualified against the previous-cycle row/column, so a stalled scan cannot re-fire it.
- FSM states:
  - WAIT: on frame_tick_o && !pause_i go to UPD_H; otherwise stay.
  - UPD_H: compute the horizontal step, go to UPD_V.
  - UPD_V: compute the vertical step, go to WAIT.
  - pause_i is sampled only in WAIT.
- Position update completes 3 cycles after the tick cycle, well inside vblank, so there is no mid-frame tearing.
- Axis step rule, with MAX_H=H_ACTIVE-SIZE and MAX_V=V_ACTIVE-SIZE, in 17-bit unsigned arithmetic:
  - Positive direction: if pos+speed >= MAX, then pos=MAX, reverse direction, pulse bounce; else pos+=speed.
  - Negative direction: if pos <= speed, then pos=0, reverse direction, pulse bounce; else pos-=speed.
  - pos==0 or pos==MAX with speed 0 still bounces (reverses direction and pulses).
- Each bounce pulse is high for the single cycle after its UPD state. In a corner hit, both bounce_h_o and bounce_v_o pulse, on consecutive cycles.
- speed inputs are sampled in their respective UPD state.
- Pixel path:
  - hit = (column_i >= ball_h) && (column_i < ball_h+SIZE) && (row_i >= ball_v) && (row_i < ball_v+SIZE).
  - rgb_o registered: BALL_COLOR if hit else BG_COLOR. Latency 1 cycle from row_i/column_i.
  - Outside the visible area (row_i>=V_ACTIVE or column_i>=H_ACTIVE), rgb_o=BG_COLOR.
- ball_h_o/ball_v_o are direct register outputs.

Optional Feature:
BALL_BOUNCE_COUNT_EN:
- When defined: adds output bounce_cnt_o [15:0]. It increments by 1 per bounce pulse (corner = +2 across two cycles), wraps from 16'hFFFF to 0, and resets to 0.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
1. Reset then idle scan -> ball_h_o=128, ball_v_o=128. rgb_o=16'h0000 at row 0 col 0. No pulses.
2. Scan row 128, cols 127..132 -> rgb_o one cycle later is 0000, FFFF, FFFF, FFFF, FFFF, 0000. Row 132, col 128 -> 0000.
3. speed 2/2, one frame tick -> 3 cycles after the tick, ball = (126,130). pause_i=1 on the next tick -> position unchanged.
4. H_INIT=1, speed_h=2, tick -> ball_h=0, bounce_h_o pulses once. Next tick -> ball_h=2. Count-enabled build: bounce_cnt_o=1.
5. Corner: ball=(636,476), directions +/+, speed 3 -> ball=(636,476) (MAX clamp), bounce_h_o then bounce_v_o on consecutive cycles. Next tick -> (633,473).
6. reset_i asserted in the UPD_H cycle -> the next cycle shows ball=(128,128), FSM=WAIT, no bounce pulse.
